// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with a 2-entry skid buffer (output reg + skid reg).
// in_ready depends only on registered state, so out_ready has no combinational path to it.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | output and skid registers both invalid
// ST_ONE   | output register valid, skid register invalid
// ST_FULL  | output and skid registers both valid
module imm_ext_pipe #(
   parameter int IMM_W    = 16,
   parameter int DATA_W   = 32,
   parameter int BR_SHIFT = 2,
   parameter int TAG_W    = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [2:0]        in_mode,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_ext,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err
);

   localparam int PAD_W = DATA_W - IMM_W;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [DATA_W-1:0] or_ext_q, or_ext_d;
   logic [TAG_W-1:0]  or_tag_q, or_tag_d;
   logic              or_err_q, or_err_d;
   logic [DATA_W-1:0] sr_ext_q, sr_ext_d;
   logic [TAG_W-1:0]  sr_tag_q, sr_tag_d;
   logic              sr_err_q, sr_err_d;

   logic [DATA_W-1:0] ext_zero, ext_sign, ext_upper, ext_branch, ext_calc;
   logic              err_calc;
   logic              in_fire, out_fire;

   always_comb begin
      ext_zero   = {{PAD_W{1'b0}}, in_imm};
      ext_sign   = {{PAD_W{in_imm[IMM_W-1]}}, in_imm};
      ext_upper  = {in_imm, {PAD_W{1'b0}}};
      ext_branch = ext_sign << BR_SHIFT;
      ext_calc   = '0;
      err_calc   = 1'b0;
      case (in_mode)
         3'd0:    ext_calc = ext_zero;
         3'd1:    ext_calc = ext_sign;
         3'd2:    ext_calc = ext_upper;
         3'd3:    ext_calc = ext_branch;
         default: err_calc = 1'b1;
      endcase
   end

   assign in_ready  = (state_q != ST_FULL);
   assign out_valid = (state_q != ST_EMPTY);
   assign out_ext   = or_ext_q;
   assign out_tag   = or_tag_q;
   assign out_err   = or_err_q;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_comb begin
      state_d  = state_q;
      or_ext_d = or_ext_q;
      or_tag_d = or_tag_q;
      or_err_d = or_err_q;
      sr_ext_d = sr_ext_q;
      sr_tag_d = sr_tag_q;
      sr_err_d = sr_err_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               state_d  = ST_ONE;
               or_ext_d = ext_calc;
               or_tag_d = in_tag;
               or_err_d = err_calc;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               or_ext_d = ext_calc;
               or_tag_d = in_tag;
               or_err_d = err_calc;
            end else if (in_fire) begin
               state_d  = ST_FULL;
               sr_ext_d = ext_calc;
               sr_tag_d = in_tag;
               sr_err_d = err_calc;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so the only event is the skid entry moving up.
            if (out_fire) begin
               state_d  = ST_ONE;
               or_ext_d = sr_ext_q;
               or_tag_d = sr_tag_q;
               or_err_d = sr_err_q;
               sr_ext_d = '0;
               sr_tag_d = '0;
               sr_err_d = 1'b0;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_EMPTY;
         or_ext_q <= '0;
         or_tag_q <= '0;
         or_err_q <= 1'b0;
         sr_ext_q <= '0;
         sr_tag_q <= '0;
         sr_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         or_ext_q <= or_ext_d;
         or_tag_q <= or_tag_d;
         or_err_q <= or_err_d;
         sr_ext_q <= sr_ext_d;
         sr_tag_q <= sr_tag_d;
         sr_err_q <= sr_err_d;
      end
   end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate-extension stage for the pipelined MIPS datapath. It replaces the single-mode combinational extender.
- Accepts an immediate plus an extension-mode code over a valid/ready handshake and produces the extended DATA_W-bit operand one cycle later.
- A 2-entry skid buffer sustains full throughput under decode/execute stalls.
- Sits between instruction decode and the ID/EX operand mux.

Parameters:
- IMM_W, 16, immediate field width (bits). Must be less than DATA_W.
- DATA_W, 32, extended operand width (bits).
- BR_SHIFT, 2, left shift applied in branch mode (word offset to byte offset).
- TAG_W, 5, width of the sideband tag carried alongside each operand (e.g. destination register).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the rising edge of clk; state clears when reset==0.
- in_valid  input  1  input transaction present.
- in_ready  output  1  stage can accept an input this cycle.
- in_imm  input  IMM_W  raw immediate field.
- in_mode  input  3  extension mode (see Behaviour).
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  out_* fields hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_ext  output  DATA_W  extended operand.
- out_tag  output  TAG_W  tag of the result.
- out_err  output  1  result came from a reserved mode.

Behaviour:
- Modes, computed combinationally at the input and then registered:
  - 0 ZERO: {(DATA_W-IMM_W) zeros, imm}.
  - 1 SIGN: {(DATA_W-IMM_W) copies of imm[IMM_W-1], imm}.
  - 2 UPPER: {imm, (DATA_W-IMM_W) zeros} (lui).
  - 3 BRANCH: SIGN result shifted left by BR_SHIFT. Bits shifted out the top are discarded; the low BR_SHIFT bits are zero.
  - 4..7 reserved: ext = 0, err = 1.
  - err = 0 for modes 0..3.
- Storage: output register (OR) drives out_*, plus one skid register (SR). Each holds {ext, tag, err, valid}.
- Handshakes:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - in_ready = !SR.valid. It depends only on registered state, so there is no combinational path from out_ready.
- Latency: 1 cycle. An input accepted in cycle N appears on out_* in cycle N+1 when OR is empty or draining.
- Throughput: 1 result per cycle when out_ready is held high.
- States: EMPTY (OR and SR invalid), ONE (OR valid), FULL (OR and SR valid). Transitions per clock edge:
  - EMPTY + input -> ONE: OR loads the input.
  - ONE + input + output transfer -> ONE: OR loads the input.
  - ONE + input, no output transfer -> FULL: SR loads the input.
  - ONE + output transfer, no input -> EMPTY.
  - FULL + output transfer -> ONE: OR loads SR, SR cleared. No input is possible in FULL because in_ready = 0.
  - Otherwise hold.
- Ordering: strict FIFO. SR contents always reach OR before any newer input.
- Output stability: while out_valid && !out_ready, out_ext, out_tag and out_err must not change.
- Reset (reset==0 at a clock edge):
  - out_valid = 0, SR.valid = 0, out_ext = 0, out_tag = 0, out_err = 0.
  - in_ready reads 1 from the first cycle after reset deasserts. During reset, in_ready = 1 but no input is accepted.
  - Reset mid-operation discards both held entries silently.
- in_valid while in_ready = 0: no transfer. Upstream must hold its data; the block does not latch it.
- X on in_* while in_valid = 0 must not propagate into state.

Test Plan:
- Mode sweep, out_ready = 1, in_imm = 16'h8001 in modes 0/1/2/3/5 on consecutive cycles -> out_ext on the next cycles = 32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004, 32'h00000000. out_err = 0,0,0,0,1. One result per cycle.
- Positive-branch boundary, in_imm = 16'h7FFF, mode 3 -> out_ext = 32'h0001FFFC. in_imm = 16'hFFFF, mode 1 -> 32'hFFFFFFFF.
- Backpressure:
  - Hold out_ready = 0 and offer tags 1,2,3 back-to-back with in_valid = 1 -> tags 1 and 2 accepted; in_ready = 0 from the cycle after tag 2 is accepted; tag 3 is held upstream.
  - Then raise out_ready -> outputs tag 1,2,3 in order, no loss or duplication.
  - out_* stable during every stall cycle.
- Simultaneous push/pop in ONE (out_ready = 1, in_valid = 1 continuously for 8 transfers) -> in_ready stays 1, SR never loaded, 8 outputs in order.
- Reset mid-operation: reach FULL, then drive reset = 0 for one cycle -> next cycle out_valid = 0, in_ready = 1, out_ext = 0. A fresh mode-1 input 16'h0010 yields 32'h00000010 one cycle later.
- Parameter build IMM_W = 12, DATA_W = 16, BR_SHIFT = 1, in_imm = 12'h801:
  - mode 1 -> 16'hF801.
  - mode 2 -> 16'h8010.
  - mode 3 -> 16'hF002.
